// File: rtl/param_bus_ram_pkg.sv
// Shared types and constants for the param_bus_ram wait-state bus memory.
package param_bus_ram_pkg;

    localparam int unsigned WAIT_MAX = 15;
    localparam int unsigned CNT_W    = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WAIT   = 2'd1,
        ACCESS = 2'd2,
        DONE   = 2'd3
    } state_t;

    // Even parity bit for one byte: byte plus bit carries an even number of ones.
    function automatic logic even_parity(input logic [7:0] b);
        return ^b;
    endfunction

endpackage

// File: rtl/param_bus_ram_mem.sv
// Single-port byte-enabled storage with registered read.
// With PARAM_BUS_RAM_PARITY_EN defined, one even-parity bit per byte is kept alongside the data.
module param_bus_ram_mem
    import param_bus_ram_pkg::*;
#(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned DEPTH  = 16384,
    parameter int unsigned AW     = 14
) (
    input  logic                clk,
    input  logic                we,
    input  logic                re,
    input  logic [AW-1:0]       addr,
    input  logic [DATA_W/8-1:0] be,
    input  logic [DATA_W-1:0]   wdata,
`ifdef PARAM_BUS_RAM_PARITY_EN
    input  logic                err_inject,
    output logic                rperr,
`endif
    output logic [DATA_W-1:0]   rdata
);

    localparam int unsigned NB = DATA_W / 8;

    logic [DATA_W-1:0] mem [DEPTH];

    // Byte-masked write and registered read share the single port.
    always_ff @(posedge clk) begin
        if (we) begin
            for (int i = 0; i < int'(NB); i++) begin
                if (be[i]) begin
                    mem[addr][i*8 +: 8] <= wdata[i*8 +: 8];
                end
            end
        end
        if (re) begin
            rdata <= mem[addr];
        end
    end

`ifdef PARAM_BUS_RAM_PARITY_EN
    logic [NB-1:0] par [DEPTH];
    logic [NB-1:0] chk_c;

    always_comb begin
        chk_c = '0;
        for (int i = 0; i < int'(NB); i++) begin
            chk_c[i] = even_parity(mem[addr][i*8 +: 8]) ^ par[addr][i];
        end
    end

    // Injection flips the stored parity so the next read of that byte reports an error.
    always_ff @(posedge clk) begin
        if (we) begin
            for (int i = 0; i < int'(NB); i++) begin
                if (be[i]) begin
                    par[addr][i] <= even_parity(wdata[i*8 +: 8]) ^ err_inject;
                end
            end
        end
        if (re) begin
            rperr <= |chk_c;
        end
    end
`endif

endmodule

// File: rtl/param_bus_ram.sv
// Chip-select bus memory with programmable wait states and one-cycle ready pulse.
// Optional byte parity and err_inject port under PARAM_BUS_RAM_PARITY_EN.
module param_bus_ram
    import param_bus_ram_pkg::*;
#(
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned ADDR_W      = 16,
    parameter int unsigned DEPTH       = 16384,
    parameter int unsigned WAIT_STATES = 0
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [ADDR_W-1:0]   addr,
    input  logic                cs,
    input  logic                rw,
    input  logic [DATA_W/8-1:0] be,
    input  logic [DATA_W-1:0]   data_in,
`ifdef PARAM_BUS_RAM_PARITY_EN
    input  logic                err_inject,
`endif
    output logic                ready,
    output logic                err,
    output logic [DATA_W-1:0]   data_out
);

    localparam int unsigned NB     = DATA_W / 8;
    localparam int unsigned OFF_W  = $clog2(NB);
    localparam int unsigned IDX_W  = ADDR_W - OFF_W;
    localparam int unsigned MEM_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CNT_W-1:0] WAIT_LOAD = CNT_W'(WAIT_STATES - 1);

    state_t            state, state_next;
    logic [CNT_W-1:0]  cnt, cnt_next;

    logic [IDX_W-1:0]  idx_c;
    logic              in_range_c;
    logic              acc_fire_c;
    logic              mem_we_c;
    logic              mem_re_c;
    logic [MEM_AW-1:0] mem_addr_c;
    logic [DATA_W-1:0] mem_rdata;
    logic              rd_perr;

    // Result of the ACCESS edge, waiting for the registered read data.
    logic              pend;
    logic              pend_rd;
    logic              pend_oor;

    assign idx_c      = IDX_W'(addr >> OFF_W);
    assign in_range_c = (IDX_W+1)'(idx_c) < (IDX_W+1)'(DEPTH);
    assign acc_fire_c = (state == ACCESS) && cs && !reset;
    assign mem_we_c   = acc_fire_c && !rw && in_range_c;
    assign mem_re_c   = acc_fire_c && rw && in_range_c;
    assign mem_addr_c = MEM_AW'(idx_c);

    param_bus_ram_mem #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .AW     (MEM_AW)
    ) u_mem (
        .clk        (clk),
        .we         (mem_we_c),
        .re         (mem_re_c),
        .addr       (mem_addr_c),
        .be         (be),
        .wdata      (data_in),
`ifdef PARAM_BUS_RAM_PARITY_EN
        .err_inject (err_inject),
        .rperr      (rd_perr),
`endif
        .rdata      (mem_rdata)
    );

`ifndef PARAM_BUS_RAM_PARITY_EN
    assign rd_perr = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    // Next state; dropping cs before the access abandons the transaction silently.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        case (state)
            IDLE: begin
                if (cs) begin
                    if (WAIT_STATES > 0) begin
                        state_next = WAIT;
                        cnt_next   = WAIT_LOAD;
                    end else begin
                        state_next = ACCESS;
                    end
                end
            end
            WAIT: begin
                if (!cs) begin
                    state_next = IDLE;
                    cnt_next   = '0;
                end else if (cnt == '0) begin
                    state_next = ACCESS;
                end else begin
                    cnt_next = cnt - CNT_W'(1);
                end
            end
            ACCESS: begin
                state_next = cs ? DONE : IDLE;
            end
            DONE: begin
                if (!cs) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Output stage lines up ready/err with the registered read data.
    always_ff @(posedge clk) begin
        if (reset) begin
            pend     <= 1'b0;
            pend_rd  <= 1'b0;
            pend_oor <= 1'b0;
            ready    <= 1'b0;
            err      <= 1'b0;
            data_out <= '0;
        end else begin
            pend     <= acc_fire_c;
            pend_rd  <= rw;
            pend_oor <= !in_range_c;
            ready    <= pend;
            err      <= pend && (pend_oor || (pend_rd && rd_perr));
            data_out <= (pend && pend_rd && !pend_oor) ? mem_rdata : '0;
        end
    end

endmodule

// File: tb/tb_param_bus_ram.sv
// Self-checking bench for param_bus_ram: three instances (0, 3 and 4 wait states) against a word-array model.
module tb_param_bus_ram;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] addr;
    logic        rw;
    logic [3:0]  be;
    logic [31:0] data_in;
    logic        inj;
    logic [2:0]  cs_v;
    logic [2:0]  ready_v;
    logic [2:0]  err_v;
    logic [31:0] dout_v [3];

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

`ifndef PARAM_BUS_RAM_PARITY_EN
    logic inj_unused;
    assign inj_unused = inj;
`endif

    param_bus_ram #(.DATA_W(32), .ADDR_W(16), .DEPTH(16384), .WAIT_STATES(0)) dut0 (
        .clk(clk), .reset(reset), .addr(addr), .cs(cs_v[0]), .rw(rw), .be(be), .data_in(data_in),
`ifdef PARAM_BUS_RAM_PARITY_EN
        .err_inject(inj),
`endif
        .ready(ready_v[0]), .err(err_v[0]), .data_out(dout_v[0]));

    param_bus_ram #(.DATA_W(32), .ADDR_W(16), .DEPTH(1024), .WAIT_STATES(3)) dut3 (
        .clk(clk), .reset(reset), .addr(addr), .cs(cs_v[1]), .rw(rw), .be(be), .data_in(data_in),
`ifdef PARAM_BUS_RAM_PARITY_EN
        .err_inject(inj),
`endif
        .ready(ready_v[1]), .err(err_v[1]), .data_out(dout_v[1]));

    param_bus_ram #(.DATA_W(32), .ADDR_W(16), .DEPTH(1024), .WAIT_STATES(4)) dut4 (
        .clk(clk), .reset(reset), .addr(addr), .cs(cs_v[2]), .rw(rw), .be(be), .data_in(data_in),
`ifdef PARAM_BUS_RAM_PARITY_EN
        .err_inject(inj),
`endif
        .ready(ready_v[2]), .err(err_v[2]), .data_out(dout_v[2]));

    // One bus transaction on instance sel; lat counts edges after the cs sampling edge (-1 = timed out).
    task automatic xact(input int sel, input logic rw_i, input logic [15:0] a, input logic [3:0] b,
                        input logic [31:0] d, input logic inj_i, input int hold,
                        output int lat, output int pulses, output logic e, output logic [31:0] q,
                        output logic [31:0] q_idle);
        int cyc;
        bit seen;
        @(posedge clk); #1;
        addr = a; rw = rw_i; be = b; data_in = d; inj = inj_i; cs_v[sel] = 1'b1;
        lat = -1; pulses = 0; e = 1'b0; q = '0; seen = 0; cyc = 0;
        while (!seen && cyc < 60) begin
            @(posedge clk); #1;
            cyc++;
            if (ready_v[sel] === 1'b1) begin
                seen = 1; lat = cyc - 1; e = err_v[sel]; q = dout_v[sel]; pulses = 1;
            end
        end
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            if (ready_v[sel] === 1'b1) pulses++;
        end
        cs_v[sel] = 1'b0;
        inj = 1'b0;
        @(posedge clk); #1;
        if (ready_v[sel] === 1'b1) pulses++;
        q_idle = dout_v[sel];
    endtask

    task automatic test_reset();
        reset = 1'b1; cs_v = '0; addr = '0; rw = 1'b0; be = '0; data_in = '0; inj = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        for (int s = 0; s < 3; s++) begin
            checks++;
            if (ready_v[s] !== 1'b0 || err_v[s] !== 1'b0 || dout_v[s] !== 32'h0) begin
                failures++;
                $display("FAIL reset_outputs dut%0d got ready=%b err=%b data=%h exp 0/0/0", s, ready_v[s], err_v[s], dout_v[s]);
            end
        end
        reset = 1'b0;
    endtask

    task automatic test_basic();
        int lat, pulses; logic e; logic [31:0] q, qi;
        xact(0, 1'b0, 16'h0010, 4'hF, 32'hDEADBEEF, 1'b0, 0, lat, pulses, e, q, qi);
        checks++;
        if (lat !== 2 || pulses !== 1 || e !== 1'b0) begin
            failures++;
            $display("FAIL basic_write got lat=%0d pulses=%0d err=%b exp 2/1/0", lat, pulses, e);
        end
        xact(0, 1'b1, 16'h0010, 4'h0, 32'h0, 1'b0, 0, lat, pulses, e, q, qi);
        checks++;
        if (lat !== 2 || e !== 1'b0 || q !== 32'hDEADBEEF) begin
            failures++;
            $display("FAIL basic_read got lat=%0d err=%b data=%h exp 2/0/deadbeef", lat, e, q);
        end
        checks++;
        if (qi !== 32'h0 || pulses !== 1) begin
            failures++;
            $display("FAIL basic_idle_data got data=%h pulses=%0d exp 0/1", qi, pulses);
        end
    endtask

    task automatic test_byte_enable();
        int lat, pulses; logic e; logic [31:0] q, qi;
        xact(0, 1'b0, 16'h0020, 4'hF, 32'hFFFFFFFF, 1'b0, 0, lat, pulses, e, q, qi);
        xact(0, 1'b0, 16'h0020, 4'h5, 32'h00000000, 1'b0, 0, lat, pulses, e, q, qi);
        xact(0, 1'b0, 16'h0020, 4'h0, 32'h12345678, 1'b0, 0, lat, pulses, e, q, qi);
        checks++;
        if (lat !== 2 || e !== 1'b0) begin
            failures++;
            $display("FAIL be_zero_write got lat=%0d err=%b exp 2/0", lat, e);
        end
        xact(0, 1'b1, 16'h0023, 4'hF, 32'h0, 1'b0, 0, lat, pulses, e, q, qi);
        checks++;
        if (q !== 32'hFF00FF00 || e !== 1'b0) begin
            failures++;
            $display("FAIL be_merge got data=%h err=%b exp ff00ff00/0", q, e);
        end
    endtask

    task automatic test_wait_hold();
        int lat, pulses; logic e; logic [31:0] q, qi;
        xact(1, 1'b0, 16'h0040, 4'hF, 32'hCAFEF00D, 1'b0, 0, lat, pulses, e, q, qi);
        checks++;
        if (lat !== 5) begin
            failures++;
            $display("FAIL wait3_write_latency got %0d exp 5", lat);
        end
        xact(1, 1'b1, 16'h0040, 4'hF, 32'h0, 1'b0, 10, lat, pulses, e, q, qi);
        checks++;
        if (lat !== 5 || pulses !== 1 || q !== 32'hCAFEF00D) begin
            failures++;
            $display("FAIL wait3_hold_read got lat=%0d pulses=%0d data=%h exp 5/1/cafef00d", lat, pulses, q);
        end
    endtask

    task automatic test_out_of_range();
        int lat, pulses; logic e; logic [31:0] q, qi;
        xact(1, 1'b0, 16'h0000, 4'hF, 32'hA5A50001, 1'b0, 0, lat, pulses, e, q, qi);
        xact(1, 1'b0, 16'h1000, 4'hF, 32'hFFFFFFFF, 1'b0, 0, lat, pulses, e, q, qi);
        checks++;
        if (lat !== 5 || e !== 1'b1) begin
            failures++;
            $display("FAIL oor_write got lat=%0d err=%b exp 5/1", lat, e);
        end
        xact(1, 1'b1, 16'h0000, 4'hF, 32'h0, 1'b0, 0, lat, pulses, e, q, qi);
        checks++;
        if (q !== 32'hA5A50001 || e !== 1'b0) begin
            failures++;
            $display("FAIL oor_word0_intact got data=%h err=%b exp a5a50001/0", q, e);
        end
        xact(1, 1'b1, 16'h1000, 4'hF, 32'h0, 1'b0, 0, lat, pulses, e, q, qi);
        checks++;
        if (q !== 32'h0 || e !== 1'b1 || lat !== 5) begin
            failures++;
            $display("FAIL oor_read got data=%h err=%b lat=%0d exp 0/1/5", q, e, lat);
        end
    endtask

    task automatic test_abort();
        int lat, pulses, cnt_rdy; logic e; logic [31:0] q, qi;
        xact(2, 1'b0, 16'h0080, 4'hF, 32'h0BADF00D, 1'b0, 0, lat, pulses, e, q, qi);
        checks++;
        if (lat !== 6) begin
            failures++;
            $display("FAIL wait4_latency got %0d exp 6", lat);
        end
        // Drop cs one cycle into WAIT.
        @(posedge clk); #1;
        addr = 16'h0080; rw = 1'b0; be = 4'hF; data_in = 32'h11111111; cs_v[2] = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        cs_v[2] = 1'b0;
        cnt_rdy = 0;
        repeat (10) begin
            @(posedge clk); #1;
            if (ready_v[2] === 1'b1) cnt_rdy++;
        end
        checks++;
        if (cnt_rdy !== 0) begin
            failures++;
            $display("FAIL abort_wait_ready got %0d pulses exp 0", cnt_rdy);
        end
        // Reset while in ACCESS (five edges after cs sampled).
        addr = 16'h0080; rw = 1'b0; be = 4'hF; data_in = 32'h22222222; cs_v[2] = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0; cs_v[2] = 1'b0;
        checks++;
        if (ready_v[2] !== 1'b0 || err_v[2] !== 1'b0 || dout_v[2] !== 32'h0) begin
            failures++;
            $display("FAIL reset_in_access got ready=%b err=%b data=%h exp 0/0/0", ready_v[2], err_v[2], dout_v[2]);
        end
        cnt_rdy = 0;
        repeat (8) begin
            @(posedge clk); #1;
            if (ready_v[2] === 1'b1) cnt_rdy++;
        end
        checks++;
        if (cnt_rdy !== 0) begin
            failures++;
            $display("FAIL reset_access_ready got %0d pulses exp 0", cnt_rdy);
        end
        xact(2, 1'b1, 16'h0080, 4'hF, 32'h0, 1'b0, 0, lat, pulses, e, q, qi);
        checks++;
        if (q !== 32'h0BADF00D || e !== 1'b0 || lat !== 6 || pulses !== 1) begin
            failures++;
            $display("FAIL abort_location_intact got data=%h err=%b lat=%0d pulses=%0d exp 0badf00d/0/6/1", q, e, lat, pulses);
        end
    endtask

    // Random reads/writes/out-of-range on the 3-wait-state, 1024-word instance.
    task automatic test_random();
        logic [31:0] mdl [int];
        int idx_list [8];
        int lat, pulses, k, idx;
        logic e, r, oor;
        logic [31:0] q, qi, d, exp_q;
        logic [3:0] b;
        logic [15:0] a;
        for (int i = 0; i < 8; i++) begin
            idx_list[i] = int'($urandom_range(16, 1023));
            d = $urandom;
            xact(1, 1'b0, 16'(idx_list[i] * 4), 4'hF, d, 1'b0, 0, lat, pulses, e, q, qi);
            mdl[idx_list[i]] = d;
        end
        for (int n = 0; n < 40; n++) begin
            oor = ($urandom_range(0, 3) == 0);
            r = 1'($urandom);
            b = 4'($urandom);
            d = $urandom;
            if (oor) begin
                a = 16'($urandom_range(16'h1000, 16'hFFFF));
                idx = 0;
            end else begin
                k = int'($urandom_range(0, 7));
                idx = idx_list[k];
                a = 16'(idx * 4 + int'($urandom_range(0, 3)));
            end
            exp_q = (r && !oor) ? mdl[idx] : 32'h0;
            xact(1, r, a, b, d, 1'b0, 0, lat, pulses, e, q, qi);
            if (!r && !oor) begin
                for (int i = 0; i < 4; i++) begin
                    if (b[i]) mdl[idx][i*8 +: 8] = d[i*8 +: 8];
                end
            end
            checks++;
            if (lat !== 5 || pulses !== 1 || e !== oor || q !== exp_q) begin
                failures++;
                $display("FAIL random_op%0d addr=%h rw=%b be=%h got lat=%0d pulses=%0d err=%b data=%h exp 5/1/%b/%h",
                         n, a, r, b, lat, pulses, e, q, oor, exp_q);
            end
        end
    endtask

`ifdef PARAM_BUS_RAM_PARITY_EN
    task automatic test_parity();
        int lat, pulses; logic e; logic [31:0] q, qi;
        xact(0, 1'b0, 16'h0100, 4'hF, 32'h12345678, 1'b1, 0, lat, pulses, e, q, qi);
        xact(0, 1'b1, 16'h0100, 4'hF, 32'h0, 1'b0, 0, lat, pulses, e, q, qi);
        checks++;
        if (q !== 32'h12345678 || e !== 1'b1) begin
            failures++;
            $display("FAIL parity_inject got data=%h err=%b exp 12345678/1", q, e);
        end
        xact(0, 1'b0, 16'h0100, 4'hF, 32'h12345678, 1'b0, 0, lat, pulses, e, q, qi);
        xact(0, 1'b1, 16'h0100, 4'hF, 32'h0, 1'b0, 0, lat, pulses, e, q, qi);
        checks++;
        if (q !== 32'h12345678 || e !== 1'b0) begin
            failures++;
            $display("FAIL parity_clean got data=%h err=%b exp 12345678/0", q, e);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_byte_enable();
        test_wait_hold();
        test_out_of_range();
        test_abort();
        test_random();
`ifdef PARAM_BUS_RAM_PARITY_EN
        test_parity();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
